sonar_frame_tx_ctrl: RTL and testbench
======================================

Name: sonar_frame_tx_ctrl

Overview:
- Sequences the serial UART for one sonar report.
- On a start request it latches the current angle and distance (3 BCD digits each) and builds an ASCII frame "AAA,DDD#".
- Sends the frame one character at a time through the existing UART transmitter using its partida/pronto handshake, then signals completion.
- Sits between the sonar control unit and the UART; replaces ad-hoc character muxing in the sonar datapath.

Parameters:
SEPARATOR, 7'h2C, ASCII code sent after the angle digits (',')
TERMINATOR, 7'h23, ASCII code sent after the distance digits ('#')
TIMEOUT_CYCLES, 100000, max cycles spent waiting for pronto_serial per character before aborting (minimum 2)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous reset, active-low (all state cleared while 0)
iniciar  input  1  start request, sampled only in IDLE
angulo  input  12  angle BCD digits: [11:8] hundreds, [7:4] tens, [3:0] units
distancia  input  12  distance BCD digits, same layout
pronto_serial  input  1  one-cycle pulse from UART: character transmitted
partida_serial  output  1  one-cycle pulse to UART: start transmitting dado_serial
dado_serial  output  7  ASCII character presented to UART
ocupado  output  1  high from the latch edge until return to IDLE
pronto  output  1  one-cycle pulse: full frame sent
erro  output  1  one-cycle pulse: frame aborted on timeout
db_estado  output  4  current FSM state code, for hexa7seg debug display

Behaviour:
- Reset (reset=0):
  - State IDLE; index=0; timeout counter=0; latched digits=0.
  - All outputs 0, dado_serial=7'h00.
  - Asynchronous: takes effect mid-frame immediately, and no further partida_serial is issued.
- States and db_estado codes: IDLE=0, SEND=1, WAIT=2, DONE=3, ERRO=F.
- IDLE:
  - At a clock edge with iniciar=1, latch angulo and distancia, set index=0, go to SEND.
  - iniciar is ignored in every other state (no queuing).
- SEND (exactly one cycle):
  - partida_serial=1; dado_serial=char[index]; next state WAIT; timeout counter cleared.
- WAIT:
  - dado_serial held at char[index] (stable for the whole UART transfer); counter increments each cycle.
  - pronto_serial=1 and index is the last character: go to DONE.
  - pronto_serial=1 otherwise: index+1, go to SEND.
  - No pronto_serial when the counter reaches TIMEOUT_CYCLES-1: go to ERRO.
  - pronto_serial coincident with timeout: pronto_serial wins.
- DONE: pronto=1 for one cycle, then IDLE.
- ERRO: erro=1 for one cycle, then IDLE. The partial frame is not resumed.
- ocupado=1 in SEND, WAIT, DONE and ERRO.
- Character map (index 0..7):
  - 0..2: angle hundreds, tens, units.
  - 3: SEPARATOR.
  - 4..6: distance hundreds, tens, units.
  - 7: TERMINATOR.
- Digit conversion: ASCII = 7'h30 + digit. A digit > 9 (invalid BCD) is sent as '?' (7'h3F).
- Latency: first partida_serial is asserted in the cycle after the iniciar edge. pronto is asserted 1 cycle after the 8th pronto_serial.
- pronto_serial arriving in IDLE, SEND, DONE or ERRO is ignored.
- Changes on angulo/distancia after the latch edge do not affect the frame in flight.

Optional Feature:
CHECKSUM_EN:
- Defined: frame is 9 characters. char[8] = 7'h40 | (XOR of char[0..7] bits [5:0]); DONE follows pronto_serial of char[8].
- Undefined: 8-character frame as above; no checksum logic synthesized.

Test Plan:
1. reset=1, angulo=12'h090, distancia=12'h123, iniciar pulse; UART model returns pronto_serial 20 cycles after each partida -> 8 partida pulses with dado 30,39,30,2C,31,32,33,23 (hex); pronto pulse 1 cycle after the 8th pronto_serial; ocupado high throughout. With CHECKSUM_EN, a 9th character 7'h46 follows.
2. distancia=12'h1A5 -> 5th..7th characters 31,3F,35 (hex).
3. TIMEOUT_CYCLES=50; UART never responds after the 3rd partida -> erro pulse exactly 50 cycles after the 3rd partida; no 4th partida; returns to IDLE; a new iniciar restarts at char 0.
4. iniciar pulsed again during WAIT of char 2, and angulo changed mid-frame -> no extra partida; frame contents unchanged; exactly one pronto.
5. reset driven low during WAIT of char 5 -> outputs 0 immediately (asynchronous); after release, no partida until a new iniciar.
6. pronto_serial arriving on the same cycle the counter reaches TIMEOUT_CYCLES-1 -> proceeds to the next SEND; no erro.

Source files
------------

// File: rtl/sonar_frame_tx_ctrl.sv
// Sends one sonar report "AAA,DDD#" through the UART partida/pronto handshake.
// Optional: define CHECKSUM_EN to append a 9th checksum character.
module sonar_frame_tx_ctrl #(
  parameter logic [6:0] SEPARATOR      = 7'h2C,
  parameter logic [6:0] TERMINATOR     = 7'h23,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        iniciar,
  input  logic [11:0] angulo,
  input  logic [11:0] distancia,
  input  logic        pronto_serial,
  output logic        partida_serial,
  output logic [6:0]  dado_serial,
  output logic        ocupado,
  output logic        pronto,
  output logic        erro,
  output logic [3:0]  db_estado
);

`ifdef CHECKSUM_EN
  localparam int NUM_CHARS = 9;
`else
  localparam int NUM_CHARS = 8;
`endif
  localparam int IDX_W = $clog2(NUM_CHARS);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHARS - 1);
  // Leaving WAIT when the incremented count hits TIMEOUT_CYCLES-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

  typedef enum logic [3:0] {
    ST_IDLE = 4'h0,
    ST_SEND = 4'h1,
    ST_WAIT = 4'h2,
    ST_DONE = 4'h3,
    ST_ERRO = 4'hF
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [11:0]      ang_q, ang_d;
  logic [11:0]      dist_q, dist_d;
  logic [6:0]       base_chars [8];
  logic [6:0]       cur_char;

  function automatic logic [6:0] digit_ascii(input logic [3:0] d);
    if (d > 4'd9) return 7'h3F;
    return 7'h30 + {3'b000, d};
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_digits
      assign base_chars[gi]     = digit_ascii(ang_q[11-4*gi -: 4]);
      assign base_chars[gi + 4] = digit_ascii(dist_q[11-4*gi -: 4]);
    end
  endgenerate
  assign base_chars[3] = SEPARATOR;
  assign base_chars[7] = TERMINATOR;

`ifdef CHECKSUM_EN
  logic [5:0] csum;
  always_comb begin
    csum = '0;
    for (int i = 0; i < 8; i++) csum = csum ^ base_chars[i][5:0];
  end
  assign cur_char = (idx_q == 4'd8) ? {1'b1, csum} : base_chars[idx_q[2:0]];
`else
  assign cur_char = base_chars[idx_q];
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      ang_q   <= '0;
      dist_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ang_q   <= ang_d;
      dist_q  <= dist_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    cnt_d          = cnt_q;
    ang_d          = ang_q;
    dist_d         = dist_q;
    partida_serial = 1'b0;
    dado_serial    = 7'h00;
    ocupado        = 1'b1;
    pronto         = 1'b0;
    erro           = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ocupado = 1'b0;
        if (iniciar) begin
          ang_d   = angulo;
          dist_d  = distancia;
          idx_d   = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        partida_serial = 1'b1;
        dado_serial    = cur_char;
        cnt_d          = '0;
        state_d        = ST_WAIT;
      end
      ST_WAIT: begin
        dado_serial = cur_char;
        cnt_d       = cnt_q + CNT_W'(1);
        // A pronto_serial on the timeout cycle still counts as success.
        if (pronto_serial) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_SEND;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_ERRO;
        end
      end
      ST_DONE: begin
        pronto  = 1'b1;
        state_d = ST_IDLE;
      end
      ST_ERRO: begin
        erro    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        ocupado = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign db_estado = state_q;

endmodule

// File: tb/tb_sonar_frame_tx_ctrl.sv
// Scoreboard bench for sonar_frame_tx_ctrl: stimulus queues expected UART events, a monitor checks them.
module tb_sonar_frame_tx_ctrl;
  localparam int TO = 50;
`ifdef CHECKSUM_EN
  localparam int NCH = 9;
`else
  localparam int NCH = 8;
`endif

  localparam logic [0:8][6:0] F1 = {7'h30, 7'h39, 7'h30, 7'h2C, 7'h31, 7'h32, 7'h33, 7'h23, 7'h46};
  localparam logic [0:8][6:0] F2 = {7'h30, 7'h39, 7'h30, 7'h2C, 7'h31, 7'h3F, 7'h35, 7'h23, 7'h4D};
  localparam logic [0:8][6:0] F4 = {7'h39, 7'h38, 7'h37, 7'h2C, 7'h30, 7'h35, 7'h30, 7'h23, 7'h4C};
  localparam logic [0:8][6:0] F6 = {7'h30, 7'h34, 7'h35, 7'h2C, 7'h36, 7'h37, 7'h38, 7'h23, 7'h47};

  logic        clock = 1'b0;
  logic        reset;
  logic        iniciar;
  logic [11:0] angulo;
  logic [11:0] distancia;
  logic        pronto_serial = 1'b0;
  logic        partida_serial;
  logic [6:0]  dado_serial;
  logic        ocupado;
  logic        pronto;
  logic        erro;
  logic [3:0]  db_estado;

  sonar_frame_tx_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .angulo(angulo),
    .distancia(distancia), .pronto_serial(pronto_serial),
    .partida_serial(partida_serial), .dado_serial(dado_serial),
    .ocupado(ocupado), .pronto(pronto), .erro(erro), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // kind: 0 partida, 1 pronto, 2 erro
  typedef struct { int kind; logic [6:0] ch; int cyc; } ev_t;
  // kind: 0 busy (ocupado=1), 1 idle (all outputs 0)
  typedef struct { int kind; int cyc; } st_t;
  ev_t ev_q[$];
  st_t st_q[$];

  int n_cmp = 0;
  int n_mis = 0;
  logic [6:0] last_ch = 7'h00;

  int uart_delay = 20;
  int uart_limit = 99;
  int uart_cnt = 0;
  int pend = 0;

  // UART model: answers the first uart_limit partidas of a frame after uart_delay cycles.
  always @(negedge clock) begin
    if (reset !== 1'b1) begin
      pend = 0;
      pronto_serial = 1'b0;
      uart_cnt = 0;
    end else begin
      pronto_serial = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) pronto_serial = 1'b1;
      end
      if (ocupado === 1'b0) uart_cnt = 0;
      if (partida_serial === 1'b1) begin
        uart_cnt++;
        if (uart_cnt <= uart_limit) pend = uart_delay;
      end
    end
  end

  always @(negedge clock) begin
    ev_t it;
    st_t s;
    int  k;
    while (st_q.size() > 0 && st_q[0].cyc <= cyc) begin
      s = st_q.pop_front();
      n_cmp++;
      if (s.kind == 0) begin
        if (ocupado !== 1'b1) begin
          n_mis++;
          $display("FAIL busy cyc=%0d: ocupado=%b, required 1", cyc, ocupado);
        end
      end else if ({ocupado, partida_serial, pronto, erro, db_estado, dado_serial} !== 15'h0) begin
        n_mis++;
        $display("FAIL idle cyc=%0d: ocupado=%b partida=%b pronto=%b erro=%b estado=%h dado=%h, required all 0",
                 cyc, ocupado, partida_serial, pronto, erro, db_estado, dado_serial);
      end
    end
    while (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
      it = ev_q.pop_front();
      n_cmp++;
      n_mis++;
      $display("FAIL missing_event: kind=%0d ch=%h not seen, required at cyc %0d", it.kind, it.ch, it.cyc);
    end
    if (reset === 1'b1 && (partida_serial === 1'b1 || pronto === 1'b1 || erro === 1'b1)) begin
      k = (partida_serial === 1'b1) ? 0 : ((pronto === 1'b1) ? 1 : 2);
      n_cmp++;
      if (ev_q.size() == 0) begin
        n_mis++;
        $display("FAIL unexpected_event: kind=%0d dado=%h at cyc %0d, required none", k, dado_serial, cyc);
      end else begin
        it = ev_q.pop_front();
        if (it.kind != k || it.cyc != cyc || (k == 0 && it.ch !== dado_serial)) begin
          n_mis++;
          $display("FAIL event: kind=%0d dado=%h cyc=%0d, required kind=%0d ch=%h cyc=%0d",
                   k, dado_serial, cyc, it.kind, it.ch, it.cyc);
        end else begin
          $display("event kind=%0d ch=%h cyc=%0d ok", k, dado_serial, cyc);
        end
        if (k == 0) last_ch = it.ch;
      end
    end
    if (reset === 1'b1 && db_estado == 4'h2) begin
      n_cmp++;
      if (dado_serial !== last_ch) begin
        n_mis++;
        $display("FAIL dado_hold cyc=%0d: dado=%h, required %h", cyc, dado_serial, last_ch);
      end
    end
  end

  // Called at a negedge; iniciar is sampled at the following posedge.
  task automatic launch(input logic [11:0] a, input logic [11:0] dd, input logic [0:8][6:0] fr,
                        input int d, input int n_ok, input int n_part, input int term,
                        input bit busy, output int n0);
    int n;
    int endc;
    n = cyc;
    n0 = n;
    uart_delay = d;
    uart_limit = n_ok;
    for (int k = 0; k < n_part; k++) ev_q.push_back('{0, fr[k], n + 1 + k * (d + 1)});
    if (term == 1) begin
      endc = n + 1 + NCH * (d + 1);
      ev_q.push_back('{1, 7'h00, endc});
    end else if (term == 2) begin
      endc = n + 1 + n_ok * (d + 1) + TO;
      ev_q.push_back('{2, 7'h00, endc});
    end else begin
      endc = n + n_part * (d + 1);
    end
    if (busy) for (int c = n + 1; c <= endc; c++) st_q.push_back('{0, c});
    if (term != 0) st_q.push_back('{1, endc + 1});
    angulo = a;
    distancia = dd;
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
  endtask

  task automatic wait_empty();
    int b;
    b = 0;
    while ((ev_q.size() > 0 || st_q.size() > 0) && b < 3000) begin
      @(negedge clock);
      b++;
    end
    if (b >= 3000) begin
      $display("FAIL wait_empty: %0d events still queued, required 0", ev_q.size());
      $fatal(1, "bench timeout");
    end
    repeat (2) @(negedge clock);
  endtask

  initial begin
    int n;
    reset = 1'b0;
    iniciar = 1'b0;
    angulo = '0;
    distancia = '0;
    @(negedge clock);
    st_q.push_back('{1, cyc + 1});
    repeat (2) @(negedge clock);
    reset = 1'b1;
    st_q.push_back('{1, cyc + 1});
    repeat (3) @(negedge clock);

    // 1: nominal frame, ocupado checked every cycle
    launch(12'h090, 12'h123, F1, 20, 99, NCH, 1, 1'b1, n);
    wait_empty();

    // 2: invalid BCD digit in distance
    launch(12'h090, 12'h1A5, F2, 20, 99, NCH, 1, 1'b0, n);
    wait_empty();

    // 3: UART silent after the 3rd partida
    launch(12'h090, 12'h123, F1, 20, 2, 3, 2, 1'b0, n);
    wait_empty();

    // 4: new frame restarts at char 0; iniciar and angle change mid-frame are ignored
    launch(12'h987, 12'h050, F4, 20, 99, NCH, 1, 1'b0, n);
    repeat (46) @(negedge clock);
    iniciar = 1'b1;
    angulo = 12'h111;
    distancia = 12'h999;
    @(negedge clock);
    iniciar = 1'b0;
    wait_empty();

    // 5: asynchronous reset during WAIT of char 5
    launch(12'h090, 12'h123, F1, 20, 99, 6, 0, 1'b0, n);
    repeat (109) @(negedge clock);
    st_q.push_back('{1, n + 111});
    @(posedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    for (int c = n + 113; c < n + 153; c += 8) st_q.push_back('{1, c});
    repeat (42) @(negedge clock);
    wait_empty();

    // 6: pronto_serial on the timeout cycle wins
    launch(12'h045, 12'h678, F6, TO - 1, 99, NCH, 1, 1'b0, n);
    wait_empty();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
